// File: rtl/weight_mem_rsp.sv
// Read responder for the BIU-to-arbiter protocol: accepts single-word reads, reads a
// 1-cycle-latency SRAM and returns in-order responses through a credit-limited FIFO.
module weight_mem_rsp #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 4096,
    parameter int DEPTH     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] req_addr,
    input  logic          req_vld,
    input  logic          req_req,
    output logic          req_rdy,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic          sram_cen,
    output logic [11:0]   sram_addr,
    input  logic [DW-1:0] sram_rdata,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    logic [CW-1:0] credit;
    logic          acc;
    logic          pop;
    logic          in_range;

    logic          s1_vld;
    logic          s1_in_range;
    logic [AW-1:0] s1_addr;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic          fifo_err  [DEPTH];

    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    logic          hold_err;

    assign in_range  = {2'b00, req_addr[AW-1:2]} < AW'(MEM_WORDS);
    assign req_rdy   = req_req & (credit < CW'(DEPTH));
    assign acc       = req_vld & req_rdy;
    assign sram_cen  = acc & in_range;
    assign sram_addr = req_addr[13:2];

    assign wr_idx  = wr_ptr[IW-1:0];
    assign rd_idx  = rd_ptr[IW-1:0];
    assign rsp_vld = (wr_ptr != rd_ptr);
    assign pop     = rsp_vld & rsp_rdy;
    assign busy    = (credit != '0);

    // Credit counts every request between acceptance and pop, so the FIFO can never overflow.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld      <= 1'b0;
            s1_in_range <= 1'b0;
            s1_addr     <= '0;
        end else begin
            s1_vld <= acc;
            if (acc) begin
                s1_in_range <= in_range;
                s1_addr     <= req_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (s1_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (s1_vld) begin
            fifo_addr[wr_idx] <= s1_addr;
            fifo_data[wr_idx] <= s1_in_range ? sram_rdata : '0;
            fifo_err[wr_idx]  <= ~s1_in_range;
        end
    end

    // Last popped entry keeps the response bus steady while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else if (pop) begin
            hold_addr <= fifo_addr[rd_idx];
            hold_data <= fifo_data[rd_idx];
            hold_err  <= fifo_err[rd_idx];
        end
    end

    assign rsp_addr = rsp_vld ? fifo_addr[rd_idx] : hold_addr;
    assign rsp_data = rsp_vld ? fifo_data[rd_idx] : hold_data;
    assign rsp_err  = rsp_vld ? fifo_err[rd_idx]  : hold_err;

endmodule

// File: tb/tb_weight_mem_rsp.sv
// Scoreboard bench for weight_mem_rsp: an SRAM model feeds the DUT, expected responses
// are queued on acceptance and compared as the DUT pops them.
module tb_weight_mem_rsp;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] req_addr;
    logic          req_vld;
    logic          req_req;
    logic          req_rdy;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic          sram_cen;
    logic [11:0]   sram_addr;
    logic [DW-1:0] sram_rdata;
    logic          busy;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          pop_cnt  = 0;
    int          acc_cnt  = 0;
    logic [31:0] last_pop_addr = '0;
    logic [31:0] sram_mem [4096];

    always #5 clk = ~clk;

    weight_mem_rsp #(.AW(AW), .DW(DW), .MEM_WORDS(4096), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_vld(req_vld), .req_req(req_req), .req_rdy(req_rdy),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .busy(busy)
    );

    function automatic logic [31:0] word_val(input int i);
        if (i == 4) return 32'hA5A5_0001;
        return 32'h3C00_0000 ^ (i * 32'h0001_0101);
    endfunction

    function automatic rsp_t model(input logic [31:0] addr);
        rsp_t r;
        r.addr = addr;
        r.err  = !(addr[31:2] < 30'd4096);
        r.data = r.err ? 32'h0 : word_val(int'(addr[13:2]));
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram_mem[i] = word_val(i);
    end

    always @(posedge clk) begin
        if (sram_cen) sram_rdata <= sram_mem[sram_addr];
    end

    // Pop before push so a response can never be matched against a request of the same cycle.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {31'b0, rsp_vld}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_addr", rsp_addr, e.addr);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                end
                last_pop_addr = rsp_addr;
                pop_cnt++;
            end
            if (req_vld && req_rdy) begin
                exp_q.push_back(model(req_addr));
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] addr, output int waits,
                        output logic cen, output logic [11:0] sa);
        req_vld  = 1'b1;
        req_addr = addr;
        waits    = 0;
        @(negedge clk);
        while (!req_rdy && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_rdy) check("accept_timeout", {31'b0, req_rdy}, 32'h1);
        cen = sram_cen;
        sa  = sram_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int base, input int target);
        int n = 0;
        while ((pop_cnt - base) < target && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, pop_cnt - base, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w;
        int          stalls;
        int          base_pop;
        int          base_acc;
        logic        cen;
        logic [11:0] sa;

        rst_n = 1'b0; req_vld = 1'b0; req_req = 1'b0; req_addr = '0; rsp_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", {31'b0, req_rdy}, 32'h0);
        check("rst_rsp_vld", {31'b0, rsp_vld}, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("rst_sram_cen", {31'b0, sram_cen}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rsp_addr", rsp_addr, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_req = 1'b1; rsp_rdy = 1'b1;

        // Single request: latency and SRAM handshake
        send(32'h10, w, cen, sa);
        req_vld = 1'b0;
        check("t1_cen", {31'b0, cen}, 32'h1);
        check("t1_sram_addr", {20'b0, sa}, 32'h4);
        @(negedge clk);
        check("t1_vld_early", {31'b0, rsp_vld}, 32'h0);
        check("t1_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        check("t1_vld", {31'b0, rsp_vld}, 32'h1);
        check("t1_addr", rsp_addr, 32'h10);
        check("t1_data", rsp_data, 32'hA5A5_0001);
        check("t1_err", {31'b0, rsp_err}, 32'h0);
        @(negedge clk);
        check("t1_idle_vld", {31'b0, rsp_vld}, 32'h0);
        check("t1_idle_busy", {31'b0, busy}, 32'h0);
        check("t1_hold_addr", rsp_addr, 32'h10);

        // Back-to-back stream at full rate
        @(posedge clk); #1;
        base_pop = pop_cnt;
        stalls   = 0;
        for (int i = 0; i < 144; i++) begin
            send(32'(i * 4), w, cen, sa);
            stalls += w;
        end
        req_vld = 1'b0;
        check("t2_stalls", stalls, 32'h0);
        @(posedge clk);
        check("t2_pops_minus1", pop_cnt - base_pop, 32'd143);
        @(posedge clk);
        check("t2_pops", pop_cnt - base_pop, 32'd144);
        check("t2_last_addr", last_pop_addr, 32'h23C);
        #1;

        // Backpressure: credit limit and stable head
        rsp_rdy  = 1'b0;
        base_pop = pop_cnt;
        base_acc = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h100 + 32'(i * 4), w, cen, sa);
                req_vld = 1'b0;
            end
            begin
                repeat (5) @(posedge clk); #2;
                check("t3_head_a", rsp_addr, 32'h100);
                repeat (3) @(posedge clk); #2;
                check("t3_accepted", acc_cnt - base_acc, 32'd4);
                check("t3_rdy_full", {31'b0, req_rdy}, 32'h0);
                check("t3_busy", {31'b0, busy}, 32'h1);
                check("t3_vld", {31'b0, rsp_vld}, 32'h1);
                check("t3_head_b", rsp_addr, 32'h100);
                check("t3_head_data", rsp_data, word_val(32'h40));
                rsp_rdy = 1'b1;
                @(negedge clk);
                check("t3_rdy_pop_cycle", {31'b0, req_rdy}, 32'h0);
                @(negedge clk);
                check("t3_rdy_after_pop", {31'b0, req_rdy}, 32'h1);
            end
        join
        drain("t3_drain", base_pop, 6);

        // Out-of-range request between in-range neighbours
        base_pop = pop_cnt;
        send(32'h3FFC, w, cen, sa);
        check("t4_cen_lo", {31'b0, cen}, 32'h1);
        check("t4_sa_lo", {20'b0, sa}, 32'hFFF);
        send(32'h4000, w, cen, sa);
        check("t4_cen_oor", {31'b0, cen}, 32'h0);
        send(32'h8, w, cen, sa);
        check("t4_cen_hi", {31'b0, cen}, 32'h1);
        check("t4_sa_hi", {20'b0, sa}, 32'h2);
        req_vld = 1'b0;
        drain("t4_drain", base_pop, 3);

        // Session drop with outstanding responses
        rsp_rdy  = 1'b0;
        base_pop = pop_cnt;
        base_acc = acc_cnt;
        for (int i = 0; i < 3; i++) send(32'h20 + 32'(i * 4), w, cen, sa);
        req_req  = 1'b0;
        req_addr = 32'h2C;
        repeat (4) @(posedge clk); #2;
        check("t5_rdy_noreq", {31'b0, req_rdy}, 32'h0);
        check("t5_no_accept", acc_cnt - base_acc, 32'd3);
        rsp_rdy = 1'b1;
        drain("t5_drain", base_pop, 3);
        req_vld = 1'b0;
        @(negedge clk);
        check("t5_busy_idle", {31'b0, busy}, 32'h0);

        // Reset in the middle of a burst drops everything
        @(posedge clk); #1;
        req_req  = 1'b1;
        rsp_rdy  = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h30 + 32'(i * 4), w, cen, sa);
        req_vld = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rsp_rdy  = 1'b1;
        base_pop = pop_cnt;
        @(negedge clk);
        check("t5_rst_vld", {31'b0, rsp_vld}, 32'h0);
        check("t5_rst_busy", {31'b0, busy}, 32'h0);
        repeat (6) @(posedge clk);
        check("t5_no_stale", pop_cnt - base_pop, 32'h0);
        #1;
        send(32'h10, w, cen, sa);
        req_vld = 1'b0;
        drain("t5_post_rst", base_pop, 1);

        check("queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
